cache_sram_arb: RTL and testbench

Arbiter and sequencer in front of one cache data/tag array built from WAY_NUM single-port synchronous SRAM ways.
- Shares the array between two requesters:
  - Port A: core lookup/store.
  - Port B: refill/writeback engine.
- Drives the per-way chip-select, write-enable, address and write data.
- Tags read returns with their owner.
- Optionally sweeps the array to zero after reset before granting any requester.

---
 rtl/cache_sram_pkg.sv | 23 ++
 rtl/cache_sram_prio.sv | 39 +++
 rtl/cache_sram_arb.sv | 156 +++++++++++++++
 tb/tb_cache_sram_arb.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_sram_pkg.sv
// Shared types and default sizes for the cache SRAM arbiter.
// The optional post-reset zeroing sweep is enabled by defining CACHE_SRAM_INIT_EN.
package cache_sram_pkg;

    localparam int unsigned PKG_ADDR_W     = 6;
    localparam int unsigned PKG_DATA_W     = 32;
    localparam int unsigned PKG_WAY_NUM    = 4;
    localparam int unsigned PKG_STARVE_MAX = 4;
    localparam int unsigned CNT_W          = 4;

    typedef enum logic {ST_INIT, ST_RUN} arb_state_e;

    typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_e;

    typedef struct packed {
        logic                   ce;
        logic                   we;
        logic [PKG_WAY_NUM-1:0] way_en;
        logic [PKG_ADDR_W-1:0]  addr;
        logic [PKG_DATA_W-1:0]  wdata;
    } sram_cmd_t;

endpackage

// File: rtl/cache_sram_prio.sv
// Two-input picker: B normally wins a tie, A is forced through after
// STARVE_MAX consecutive losses.
module cache_sram_prio
    import cache_sram_pkg::*;
#(
    parameter int unsigned STARVE_MAX = PKG_STARVE_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_a_req,
    input  logic             i_b_req,
    output logic             o_sel_a,
    output logic             o_sel_b,
    output logic [CNT_W-1:0] o_starve_nxt
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_force_a;

    always_comb begin
        w_force_a    = (r_cnt == CNT_W'(STARVE_MAX));
        o_sel_b      = i_b_req && !(i_a_req && w_force_a);
        o_sel_a      = i_a_req && !o_sel_b;
        o_starve_nxt = '0;
        // Count only cycles where A asked and lost; saturate at the limit.
        if (i_a_req && !o_sel_a) begin
            o_starve_nxt = w_force_a ? r_cnt : r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= o_starve_nxt;
        end
    end

endmodule

// File: rtl/cache_sram_arb.sv
// Arbiter/sequencer sharing one multi-way single-port SRAM array between a
// core port (A) and a refill port (B). Define CACHE_SRAM_INIT_EN for the zeroing sweep.
module cache_sram_arb
    import cache_sram_pkg::*;
#(
    parameter int unsigned ADDR_W     = PKG_ADDR_W,
    parameter int unsigned DATA_W     = PKG_DATA_W,
    parameter int unsigned WAY_NUM    = PKG_WAY_NUM,
    parameter int unsigned STARVE_MAX = PKG_STARVE_MAX
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       a_req,
    input  logic                       a_we,
    input  logic [WAY_NUM-1:0]         a_way,
    input  logic [ADDR_W-1:0]          a_addr,
    input  logic [DATA_W-1:0]          a_wdata,
    output logic                       a_gnt,
    input  logic                       b_req,
    input  logic                       b_we,
    input  logic [WAY_NUM-1:0]         b_way,
    input  logic [ADDR_W-1:0]          b_addr,
    input  logic [DATA_W-1:0]          b_wdata,
    output logic                       b_gnt,
    output logic                       sram_ce,
    output logic [WAY_NUM-1:0]         sram_way_en,
    output logic                       sram_we,
    output logic [ADDR_W-1:0]          sram_addr,
    output logic [DATA_W-1:0]          sram_wdata,
    input  logic [WAY_NUM*DATA_W-1:0]  sram_rdata,
    output logic                       rd_valid,
    output logic                       rd_owner,
    output logic [WAY_NUM*DATA_W-1:0]  rd_data,
    output logic                       init_done
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic             w_init;
    logic             w_arb_a_req;
    logic             w_arb_b_req;
    logic             w_sel_a;
    logic             w_sel_b;
    logic [CNT_W-1:0] w_starve_nxt;
    sram_cmd_t        w_cmd;
    logic             r_rd_valid;
    owner_e           r_rd_owner;
    logic             r_init_done;

`ifdef CACHE_SRAM_INIT_EN
    arb_state_e        r_state;
    logic [ADDR_W-1:0] r_init_ptr;

    assign w_init = (r_state == ST_INIT);

    // Sweep every index once, then hand the array to the requesters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_INIT;
            r_init_ptr  <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_init_ptr <= r_init_ptr + ADDR_W'(1);
                    if (r_init_ptr == ADDR_W'(DEPTH - 1)) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end
`else
    assign w_init = 1'b0;

    always_ff @(posedge clk) begin
        r_init_done <= 1'b1;
    end
`endif

    assign w_arb_a_req = a_req && !rst && !w_init;
    assign w_arb_b_req = b_req && !rst && !w_init;

    cache_sram_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk          (clk),
        .rst          (rst),
        .i_a_req      (w_arb_a_req),
        .i_b_req      (w_arb_b_req),
        .o_sel_a      (w_sel_a),
        .o_sel_b      (w_sel_b),
        .o_starve_nxt (w_starve_nxt)
    );

    // Array command: sweep write during init, otherwise the winner's fields.
    always_comb begin
        w_cmd = '0;
        if (!rst && w_init) begin
            w_cmd.ce     = 1'b1;
            w_cmd.we     = 1'b1;
            w_cmd.way_en = '1;
`ifdef CACHE_SRAM_INIT_EN
            w_cmd.addr   = PKG_ADDR_W'(r_init_ptr);
`endif
        end else if (w_sel_a) begin
            w_cmd.ce     = 1'b1;
            w_cmd.we     = a_we;
            w_cmd.way_en = PKG_WAY_NUM'(a_way);
            w_cmd.addr   = PKG_ADDR_W'(a_addr);
            w_cmd.wdata  = PKG_DATA_W'(a_wdata);
        end else if (w_sel_b) begin
            w_cmd.ce     = 1'b1;
            w_cmd.we     = b_we;
            w_cmd.way_en = PKG_WAY_NUM'(b_way);
            w_cmd.addr   = PKG_ADDR_W'(b_addr);
            w_cmd.wdata  = PKG_DATA_W'(b_wdata);
        end
    end

    assign a_gnt       = w_sel_a;
    assign b_gnt       = w_sel_b;
    assign sram_ce     = w_cmd.ce;
    assign sram_we     = w_cmd.we;
    assign sram_way_en = WAY_NUM'(w_cmd.way_en);
    assign sram_addr   = ADDR_W'(w_cmd.addr);
    assign sram_wdata  = DATA_W'(w_cmd.wdata);

    // Read return: one-cycle pipeline tagging the data with its requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_owner <= OWN_A;
        end else begin
            r_rd_valid <= (w_sel_a && !a_we) || (w_sel_b && !b_we);
            if (w_sel_a && !a_we) begin
                r_rd_owner <= OWN_A;
            end else if (w_sel_b && !b_we) begin
                r_rd_owner <= OWN_B;
            end
        end
    end

    assign rd_valid  = r_rd_valid;
    assign rd_owner  = r_rd_owner;
    assign rd_data   = r_rd_valid ? sram_rdata : '0;
    assign init_done = r_init_done;

    starve_bound: assert property (@(posedge clk) disable iff (rst)
        w_starve_nxt <= CNT_W'(STARVE_MAX));

endmodule

// File: tb/tb_cache_sram_arb.sv
// Directed bench for cache_sram_arb with a behavioural multi-way SRAM model.
// Covers the init sweep too when CACHE_SRAM_INIT_EN is defined.
module tb_cache_sram_arb;

    localparam int unsigned ADDR_W  = 6;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned WAY_NUM = 4;
    localparam int unsigned DEPTH   = 1 << ADDR_W;
    localparam int unsigned RD_W    = WAY_NUM * DATA_W;

    logic                clk;
    logic                rst;
    logic                a_req, a_we, b_req, b_we;
    logic [WAY_NUM-1:0]  a_way, b_way;
    logic [ADDR_W-1:0]   a_addr, b_addr;
    logic [DATA_W-1:0]   a_wdata, b_wdata;
    logic                a_gnt, b_gnt;
    logic                sram_ce, sram_we;
    logic [WAY_NUM-1:0]  sram_way_en;
    logic [ADDR_W-1:0]   sram_addr;
    logic [DATA_W-1:0]   sram_wdata;
    logic [RD_W-1:0]     sram_rdata;
    logic                rd_valid, rd_owner, init_done;
    logic [RD_W-1:0]     rd_data;

    int checks;
    int failures;

    logic [DATA_W-1:0] mem [WAY_NUM][DEPTH];

    cache_sram_arb dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_way(a_way), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_gnt(a_gnt),
        .b_req(b_req), .b_we(b_we), .b_way(b_way), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_gnt(b_gnt),
        .sram_ce(sram_ce), .sram_way_en(sram_way_en), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .rd_valid(rd_valid), .rd_owner(rd_owner), .rd_data(rd_data),
        .init_done(init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous SRAM per way, zero-filled at time 0.
    initial begin
        for (int w = 0; w < int'(WAY_NUM); w++)
            for (int d = 0; d < int'(DEPTH); d++)
                mem[w][d] = '0;
        sram_rdata = '0;
    end

    always @(posedge clk) begin
        for (int w = 0; w < int'(WAY_NUM); w++) begin
            if (sram_ce && sram_way_en[w]) begin
                if (sram_we) mem[w][sram_addr] <= sram_wdata;
                else         sram_rdata[w*DATA_W +: DATA_W] <= mem[w][sram_addr];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_req = 0; a_we = 0; a_way = '0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_way = '0; b_addr = '0; b_wdata = '0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle();
        a_req = 1; a_way = 4'hF;
        step(); step();
        @(negedge clk);
        checks++;
        if (a_gnt !== 1'b0 || b_gnt !== 1'b0 || sram_ce !== 1'b0 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: a_gnt=%b b_gnt=%b ce=%b rd_valid=%b, need all 0",
                     a_gnt, b_gnt, sram_ce, rd_valid);
        end
        checks++;
`ifdef CACHE_SRAM_INIT_EN
        if (init_done !== 1'b0) begin
`else
        if (init_done !== 1'b1) begin
`endif
            failures++;
            $display("FAIL reset_init_done: got %b", init_done);
        end
        idle();
    endtask

    // Drive a_req during the sweep; returns with rst released and sweep done.
    task automatic run_sweep(input string tag);
        int bad;
        bad = 0;
        a_req = 1; a_we = 0; a_way = 4'hF; a_addr = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            @(negedge clk);
            if (sram_ce !== 1'b1 || sram_we !== 1'b1 || sram_way_en !== 4'hF ||
                sram_addr !== ADDR_W'(i) || sram_wdata !== '0 || a_gnt !== 1'b0 ||
                init_done !== 1'b0) begin
                if (bad == 0)
                    $display("FAIL %s_sweep: cycle %0d ce=%b we=%b way=%h addr=%0d wd=%h gnt=%b done=%b, need 1 1 f %0d 0 0 0",
                             tag, i, sram_ce, sram_we, sram_way_en, sram_addr, sram_wdata,
                             a_gnt, init_done, i);
                bad++;
            end
            step();
        end
        checks++;
        if (bad != 0) failures++;
        @(negedge clk);
        checks++;
        if (init_done !== 1'b1 || a_gnt !== 1'b1) begin
            failures++;
            $display("FAIL %s_first_run: init_done=%b a_gnt=%b, need 1 1", tag, init_done, a_gnt);
        end
        step();
        idle();
    endtask

    task automatic test_first_cycle();
        rst = 0;
`ifdef CACHE_SRAM_INIT_EN
        run_sweep("init");
`else
        a_req = 1; a_we = 0; a_way = 4'hF; a_addr = '0;
        @(negedge clk);
        checks++;
        if (a_gnt !== 1'b1 || init_done !== 1'b1) begin
            failures++;
            $display("FAIL first_cycle_gnt: a_gnt=%b init_done=%b, need 1 1", a_gnt, init_done);
        end
        step();
        idle();
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b1 || rd_owner !== 1'b0 || init_done !== 1'b1) begin
            failures++;
            $display("FAIL first_cycle_rd: rd_valid=%b owner=%b init_done=%b, need 1 0 1",
                     rd_valid, rd_owner, init_done);
        end
`endif
        step();
    endtask

    task automatic test_idle_and_zero_mask();
        idle();
        @(negedge clk);
        checks++;
        if (sram_ce !== 0 || sram_way_en !== '0 || sram_we !== 0 || sram_addr !== '0 ||
            sram_wdata !== '0 || a_gnt !== 0 || b_gnt !== 0) begin
            failures++;
            $display("FAIL idle_cmd: ce=%b way=%h we=%b addr=%0d gnt=%b%b, need all 0",
                     sram_ce, sram_way_en, sram_we, sram_addr, a_gnt, b_gnt);
        end
        step();
        a_req = 1; a_we = 1; a_way = '0; a_addr = 6'd9; a_wdata = 32'h12345678;
        @(negedge clk);
        checks++;
        if (a_gnt !== 1 || sram_ce !== 1 || sram_way_en !== '0) begin
            failures++;
            $display("FAIL zero_mask: a_gnt=%b ce=%b way=%h, need 1 1 0", a_gnt, sram_ce, sram_way_en);
        end
        step();
        idle();
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL write_no_rdvalid: rd_valid=%b, need 0", rd_valid);
        end
        step();
    endtask

    task automatic test_write_read();
        a_req = 1; a_we = 1; a_way = 4'b0010; a_addr = 6'd5; a_wdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if (a_gnt !== 1 || sram_ce !== 1 || sram_we !== 1 || sram_way_en !== 4'b0010 ||
            sram_addr !== 6'd5 || sram_wdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL wr_cmd: gnt=%b ce=%b we=%b way=%h addr=%0d wd=%h, need 1 1 1 2 5 deadbeef",
                     a_gnt, sram_ce, sram_we, sram_way_en, sram_addr, sram_wdata);
        end
        step();
        a_we = 0; a_way = 4'hF; a_wdata = '0;
        @(negedge clk);
        checks++;
        if (a_gnt !== 1 || sram_we !== 0 || sram_way_en !== 4'hF || rd_valid !== 0) begin
            failures++;
            $display("FAIL rd_cmd: gnt=%b we=%b way=%h rd_valid=%b, need 1 0 f 0",
                     a_gnt, sram_we, sram_way_en, rd_valid);
        end
        step();
        idle();
        @(negedge clk);
        checks++;
        if (rd_valid !== 1 || rd_owner !== 0 ||
            rd_data !== {32'h0, 32'h0, 32'hDEADBEEF, 32'h0}) begin
            failures++;
            $display("FAIL raw_data: valid=%b owner=%b data=%h, need 1 0 0000000000000000deadbeef00000000",
                     rd_valid, rd_owner, rd_data);
        end
        step();
    endtask

    task automatic test_contention();
        logic exp_a;
        int bad;
        bad = 0;
        a_req = 1; a_we = 0; a_way = 4'hF; a_addr = 6'd3;
        b_req = 1; b_we = 0; b_way = 4'hF; b_addr = 6'd4;
        for (int i = 0; i < 15; i++) begin
            exp_a = (i % 5 == 4);
            @(negedge clk);
            if (a_gnt !== exp_a || b_gnt !== !exp_a ||
                sram_addr !== (exp_a ? 6'd3 : 6'd4)) begin
                if (bad == 0)
                    $display("FAIL contention: cycle %0d a_gnt=%b b_gnt=%b addr=%0d, need %b %b %0d",
                             i, a_gnt, b_gnt, sram_addr, exp_a, !exp_a, exp_a ? 3 : 4);
                bad++;
            end
            if (i > 0 && (rd_valid !== 1 || rd_owner !== ((i - 1) % 5 != 4))) begin
                if (bad == 0)
                    $display("FAIL contention_owner: cycle %0d valid=%b owner=%b", i, rd_valid, rd_owner);
                bad++;
            end
            step();
        end
        checks++;
        if (bad != 0) failures++;
        // A alone wins immediately after dropping B.
        b_req = 0;
        @(negedge clk);
        checks++;
        if (a_gnt !== 1 || b_gnt !== 0) begin
            failures++;
            $display("FAIL only_a: a_gnt=%b b_gnt=%b, need 1 0", a_gnt, b_gnt);
        end
        step();
        idle();
        step();
    endtask

    task automatic test_back_to_back();
        b_req = 1; b_we = 1; b_way = 4'hF; b_addr = 6'd1; b_wdata = 32'h11111111;
        step();
        idle();
        a_req = 1; a_we = 1; a_way = 4'b0100; a_addr = 6'd2; a_wdata = 32'h000000A2;
        step();
        idle();
        b_req = 1; b_we = 0; b_way = 4'hF; b_addr = 6'd1;
        @(negedge clk);
        checks++;
        if (b_gnt !== 1 || a_gnt !== 0) begin
            failures++;
            $display("FAIL b2b_b_gnt: b_gnt=%b a_gnt=%b, need 1 0", b_gnt, a_gnt);
        end
        step();
        idle();
        a_req = 1; a_we = 0; a_way = 4'hF; a_addr = 6'd2;
        @(negedge clk);
        checks++;
        if (rd_valid !== 1 || rd_owner !== 1 || rd_data !== {4{32'h11111111}}) begin
            failures++;
            $display("FAIL b2b_first: valid=%b owner=%b data=%h, need 1 1 11111111x4",
                     rd_valid, rd_owner, rd_data);
        end
        step();
        idle();
        @(negedge clk);
        checks++;
        if (rd_valid !== 1 || rd_owner !== 0 ||
            rd_data !== {32'h0, 32'h000000A2, 32'h0, 32'h0}) begin
            failures++;
            $display("FAIL b2b_second: valid=%b owner=%b data=%h, need 1 0 00000000000000a20000000000000000",
                     rd_valid, rd_owner, rd_data);
        end
        step();
    endtask

    task automatic test_reset_mid();
        a_req = 1; a_we = 0; a_way = 4'hF; a_addr = 6'd5;
        @(negedge clk);
        checks++;
        if (a_gnt !== 1) begin
            failures++;
            $display("FAIL mid_pre_gnt: a_gnt=%b, need 1", a_gnt);
        end
        rst = 1;
        b_req = 1; b_way = 4'hF;
        step();
        @(negedge clk);
        checks++;
        if (rd_valid !== 0 || a_gnt !== 0 || b_gnt !== 0) begin
            failures++;
            $display("FAIL mid_rst: rd_valid=%b a_gnt=%b b_gnt=%b, need 0 0 0", rd_valid, a_gnt, b_gnt);
        end
        step();
        idle();
        rst = 0;
`ifdef CACHE_SRAM_INIT_EN
        run_sweep("rerun");
`else
        @(negedge clk);
        checks++;
        if (init_done !== 1 || rd_valid !== 0) begin
            failures++;
            $display("FAIL mid_after: init_done=%b rd_valid=%b, need 1 0", init_done, rd_valid);
        end
        step();
`endif
    endtask

    initial begin
        checks = 0;
        failures = 0;
        idle();
        rst = 1;
        test_reset();
        test_first_cycle();
        test_idle_and_zero_mask();
        test_write_read();
        test_contention();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
